// File: rtl/prl_tx_message_if.sv
// rtl/prl_tx_message_if.sv - PE-to-PRL transmit request holder with watchdog-guaranteed completion
module prl_tx_message_if #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pe2pl_tx_en,
    input  logic [6:0]  pe2pl_tx_type,
    input  logic [2:0]  pe2pl_tx_sop_type,
    input  logic [22:0] pe2pl_tx_info,
    output logic        pl2pe_tx_busy,
    output logic        pl2pe_tx_ack,
    output logic [1:0]  pl2pe_tx_result,
    output logic        pl2pe_tx_overrun,
    output logic        prl_tx_if_req,
    output logic [1:0]  prl_tx_if_message_type,
    output logic [4:0]  prl_tx_if_header_type,
    output logic [2:0]  prl_tx_if_sop_type,
    output logic [22:0] prl_tx_if_info,
    input  logic        prl_tx_st_msg_taken,
    input  logic        prl_tx_st_msg_success,
    input  logic        prl_tx_st_msg_discard,
    input  logic        prl_tx_st_msg_failed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0]       RES_SUCCESS = 2'b00;
    localparam logic [1:0]       RES_DISCARD = 2'b01;
    localparam logic [1:0]       RES_FAILED  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             ack_q;
    logic [1:0]       result_q;
    logic             overrun_q;
    logic             req_q;
    logic [1:0]       msg_type_q;
    logic [4:0]       hdr_type_q;
    logic [2:0]       sop_q;
    logic [22:0]      info_q;

    logic             any_result;
    logic [1:0]       result_code;

    // Outcome pulses resolved by priority failed > discard > success
    always_comb begin
        any_result  = prl_tx_st_msg_failed | prl_tx_st_msg_discard | prl_tx_st_msg_success;
        result_code = RES_SUCCESS;
        if (prl_tx_st_msg_failed) begin
            result_code = RES_FAILED;
        end else if (prl_tx_st_msg_discard) begin
            result_code = RES_DISCARD;
        end
    end

    // Request/completion FSM with registered outputs and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            result_q   <= 2'b00;
            overrun_q  <= 1'b0;
            req_q      <= 1'b0;
            msg_type_q <= 2'b00;
            hdr_type_q <= 5'd0;
            sop_q      <= 3'd0;
            info_q     <= 23'd0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pe2pl_tx_en) begin
                        msg_type_q <= pe2pl_tx_type[6:5];
                        hdr_type_q <= pe2pl_tx_type[4:0];
                        sop_q      <= pe2pl_tx_sop_type;
                        info_q     <= pe2pl_tx_info;
                        overrun_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (any_result) begin
                        result_q <= result_code;
                        ack_q    <= 1'b1;
                        req_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else if (prl_tx_st_msg_taken) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= RES_FAILED;
                        ack_q    <= 1'b1;
                        req_q    <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (any_result) begin
                        result_q <= result_code;
                        ack_q    <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= RES_FAILED;
                        ack_q    <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
            // A request while busy is dropped but remembered until the next acceptance
            if (state_q != S_IDLE && pe2pl_tx_en) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign pl2pe_tx_busy          = busy_q;
    assign pl2pe_tx_ack           = ack_q;
    assign pl2pe_tx_result        = result_q;
    assign pl2pe_tx_overrun       = overrun_q;
    assign prl_tx_if_req          = req_q;
    assign prl_tx_if_message_type = msg_type_q;
    assign prl_tx_if_header_type  = hdr_type_q;
    assign prl_tx_if_sop_type     = sop_q;
    assign prl_tx_if_info         = info_q;

endmodule

// File: doc/prl_tx_message_if.md
# prl_tx_message_if

Protocol-layer transmit message interface: the policy-engine-to-protocol-layer counterpart of the receive message interface. It accepts one transmit request from the policy engine as a single-cycle pulse and holds it as a stable request to the PRL TX state machine. It waits for that state machine to take the message and report an outcome, then returns exactly one completion pulse with a result code to the policy engine. A watchdog counter guarantees every accepted request completes.

## Interface
- TIMEOUT_CYCLES, 1000, max cycles spent in REQ or in WAIT before forced failure (≥2)
- CNT_W, 10, width of the watchdog counter (2^CNT_W > TIMEOUT_CYCLES)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- pe2pl_tx_en  in  1  one-cycle request pulse from the PE
- pe2pl_tx_type  in  7  {message_type[1:0], header_type[4:0]}
- pe2pl_tx_sop_type  in  3  SOP type of the message
- pe2pl_tx_info  in  23  message payload fields (same bit map as the RX info bus)
- pl2pe_tx_busy  out  1  high whenever state ≠ IDLE
- pl2pe_tx_ack  out  1  one-cycle completion pulse
- pl2pe_tx_result  out  2  00 success, 01 discarded, 10 failed; valid with ack and held until the next ack
- pl2pe_tx_overrun  out  1  sticky; a request arrived while busy
- prl_tx_if_req  out  1  level request to the TX state machine
- prl_tx_if_message_type  out  2  latched type[6:5]
- prl_tx_if_header_type  out  5  latched type[4:0]
- prl_tx_if_sop_type  out  3  latched SOP type
- prl_tx_if_info  out  23  latched info
- prl_tx_st_msg_taken  in  1  pulse; TX FSM has taken the request
- prl_tx_st_msg_success  in  1  pulse; GoodCRC received
- prl_tx_st_msg_discard  in  1  pulse; message discarded because an RX message arrived
- prl_tx_st_msg_failed  in  1  pulse; retries exhausted

## Operation
- Reset values: all outputs 0, state IDLE, counter 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE
  - On pe2pl_tx_en, latch type, sop and info into the prl_tx_if_* registers, clear overrun, and go to REQ.
  - Latched fields are held unchanged until the next accepted request.
- REQ
  - prl_tx_if_req = 1. Event priority: failed > discard > success > taken.
  - failed, discard or success, with or without taken in the same cycle: go to DONE with the corresponding result.
  - taken alone: go to WAIT.
  - No event while counter == TIMEOUT_CYCLES-1: go to DONE with result failed.
- WAIT
  - prl_tx_if_req = 0.
  - failed, discard or success: go to DONE with that result, using the same priority as REQ.
  - taken is ignored.
  - Timeout rule is identical to REQ: go to DONE with result failed.
- DONE
  - Lasts exactly one cycle: ack = 1 and result is registered. Then return to IDLE.
- Watchdog counter
  - Cleared to 0 on entry to REQ and on entry to WAIT.
  - Increments by 1 in every other cycle of REQ or WAIT; held at 0 in IDLE and DONE.
  - Never wraps, because the timeout fires first.
- pe2pl_tx_en while busy (REQ, WAIT, DONE)
  - The request is dropped and overrun is set to 1.
  - The latched fields, state and counter are unaffected.
- Result inputs in IDLE or DONE are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No ack is generated for the aborted request.

## Timing
- pe2pl_tx_en sampled at edge E. prl_tx_if_req and the latched fields are valid from E through the edge after taken is sampled.
- busy rises at E, the same edge as req.
- taken sampled at edge T: req is low after T.
- Result sampled at edge R: ack = 1 for the cycle after R. busy falls at R+1, the same edge ack falls.
- Minimum request-to-ack latency: 2 edges, i.e. a result arriving in the first REQ cycle.
- A new pe2pl_tx_en is accepted in the same cycle busy is low, i.e. the cycle after ack.
- Timeout: REQ or WAIT lasts exactly TIMEOUT_CYCLES cycles; ack follows one cycle later.

## Test plan
- Normal send: pulse tx_en with type 7'h21, sop 3'd0, info 23'h0. Taken arrives 3 cycles after req rises; success 5 cycles after taken.
  - Required: req high for exactly 3 cycles; one ack pulse with result 00; fields stable until completion; busy falls with ack.
- Discard before taken: discard pulse in the second REQ cycle.
  - Required: req drops; ack with result 01; no WAIT state entered.
- Simultaneous events: taken, success and failed all pulse in the same REQ cycle.
  - Required: ack with result 10 exactly 1 cycle later.
- Timeout with TIMEOUT_CYCLES = 8: taken never arrives.
  - Required: req high exactly 8 cycles; ack with result 10 in cycle 9.
  - Repeat with taken given but no result: WAIT lasts 8 cycles, then ack with result 10.
- Overrun: second tx_en with info 23'h7FFFFF while in WAIT.
  - Required: prl_tx_if_info keeps its first value; overrun = 1 and stays 1 after ack; the next accepted request clears it.
- Reset mid-WAIT: assert rst_n low.
  - Required: all outputs 0 asynchronously; no ack after release; a following request completes normally.
